// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative mult/multu/div/divu with architectural HI/LO registers.
// Ports: clk, rst_n (async active-low); Start/Func/RsVal/RtVal from Control and the
// register file; Busy while an operation runs; Done pulses for one cycle when a
// mul/div result lands in HI/LO; HI/LO are the register outputs.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [5:0]       Func,
  input  logic [WIDTH-1:0] RsVal,
  input  logic [WIDTH-1:0] RtVal,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] p, p_step, prod;
  logic [WIDTH-1:0] m, a_mag, b_mag, quo, rem, res_hi, res_lo;
  logic [WIDTH:0] sum, sh, diff;
  logic is_div, neg_q, neg_r;
  logic idle_start, is_md, signed_op, a_neg, b_neg;
  always_comb begin
    idle_start = Start && state == IDLE;
    is_md = idle_start && Func[5:2] == 4'b0110;
    signed_op = !Func[0];
    a_neg = signed_op && RsVal[WIDTH-1];
    b_neg = signed_op && RtVal[WIDTH-1];
    a_mag = a_neg ? -RsVal : RsVal;
    b_mag = b_neg ? -RtVal : RtVal;
    // multiply: p = {partial product, remaining multiplier bits}, shifted right each step
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    // divide: p = {remainder, dividend/quotient}, shifted left each step; diff[WIDTH] is the borrow
    sh = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    diff = sh - {1'b0, m};
    p_step = !is_div ? {sum, p[WIDTH-1:1]} :
             diff[WIDTH] ? {sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0} :
                           {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    prod = neg_q ? -p : p;
    quo = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    // with a zero divisor the restoring loop leaves the dividend magnitude as the
    // remainder, so the sign fix below restores the raw dividend in HI
    rem = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
    res_lo = !is_div ? prod[WIDTH-1:0] : m == '0 ? '1 : quo;
    state_nx = state == IDLE ? (is_md ? CALC : IDLE) :
               state == CALC ? (cnt == CNT_W'(WIDTH-1) ? FIX : CALC) : IDLE;
    Busy = state == CALC || state == FIX;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      p <= '0;
      m <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      Done <= 1'b0;
      HI <= '0;
      LO <= '0;
    end else begin
      Done <= state == FIX;
      if (is_md) begin
        cnt <= '0;
        is_div <= Func[1];
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        m <= Func[1] ? b_mag : a_mag;
        p <= {{WIDTH{1'b0}}, Func[1] ? a_mag : b_mag};
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        p <= p_step;
      end
      if (state == FIX) begin
        HI <= res_hi;
        LO <= res_lo;
      end else if (idle_start && Func == 6'h11) HI <= RsVal;
      else if (idle_start && Func == 6'h13) LO <= RsVal;
    end
  end
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: directed self-checking bench for muldiv_hilo_unit.
module tb_muldiv_hilo_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [5:0] func = '0;
  logic [31:0] rs = '0, rt = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;
  muldiv_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .Start(start), .Func(func), .RsVal(rs), .RtVal(rt),
    .Busy(busy), .Done(done), .HI(hi), .LO(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  // drives one request so that the following posedge ends cycle N; returns in cycle N+1
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; func = f; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    issue(f, a, b);
    chk({tag, " busy@N+1"}, busy, 1);
    cyc(32);
    chk({tag, " busy@N+33"}, busy, 1);
    chk({tag, " done@N+33"}, done, 0);
    cyc(1);
    chk({tag, " busy@N+34"}, busy, 0);
    chk({tag, " done@N+34"}, done, 1);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    cyc(1);
    chk({tag, " done@N+35"}, done, 0);
  endtask
  initial begin
    cyc(2);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    rst_n = 1'b1;
    cyc(1);
    run_op("mult 7*-3", 6'h18, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult -1*-1", 6'h18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
    run_op("div -7/2", 6'h1a, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu 100/7", 6'h1b, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div by 0", 6'h1a, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF);
    run_op("div neg by 0", 6'h1a, 32'h87654321, 32'h0, 32'h87654321, 32'hFFFFFFFF);
    run_op("divu by 0", 6'h1b, 32'h87654321, 32'h0, 32'h87654321, 32'hFFFFFFFF);
    run_op("div overflow", 6'h1a, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    // requests while busy must be ignored, including mthi
    issue(6'h19, 32'd3, 32'd5);
    cyc(4);
    start = 1'b1; func = 6'h18; rs = 32'd100; rt = 32'd100;
    cyc(1);
    func = 6'h11; rs = 32'hDEADBEEF;
    cyc(1);
    start = 1'b0;
    chk("busy mthi hi", hi, 32'h0);
    chk("busy mthi lo", lo, 32'h80000000);
    cyc(26);
    chk("ignore busy@N+33", busy, 1);
    cyc(1);
    chk("ignore done", done, 1);
    chk("ignore hi", hi, 32'h0);
    chk("ignore lo", lo, 32'd15);
    cyc(1);
    chk("ignore no second op", busy, 0);
    // unrecognised func is dropped
    issue(6'h20, 32'h55555555, 32'h1);
    chk("other func busy", busy, 0);
    chk("other func hi", hi, 32'h0);
    chk("other func lo", lo, 32'd15);
    issue(6'h11, 32'hDEADBEEF, 32'h0);
    chk("mthi hi", hi, 32'hDEADBEEF);
    chk("mthi lo", lo, 32'd15);
    chk("mthi done", done, 0);
    chk("mthi busy", busy, 0);
    issue(6'h13, 32'h0BADF00D, 32'h0);
    chk("mtlo lo", lo, 32'h0BADF00D);
    chk("mtlo hi", hi, 32'hDEADBEEF);
    chk("mtlo done", done, 0);
    // asynchronous reset in the middle of a multiply
    issue(6'h18, 32'd7, 32'hFFFFFFFD);
    cyc(9);
    chk("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst done", done, 0);
    chk("async rst hi", hi, 0);
    chk("async rst lo", lo, 0);
    cyc(1);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      chk("post-reset no done", done, 0);
    end
    chk("post-reset busy", busy, 0);
    chk("post-reset hi", hi, 0);
    chk("post-reset lo", lo, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Iterative multiply/divide unit with the architectural HI/LO registers.
- Sits directly downstream of the Control unit in the MIPS datapath. It consumes the R-type func field for mult/multu/div/divu/mthi/mtlo, and supplies HI/LO to the register write-back mux for mfhi/mflo.
- Asserts Busy so the pipeline can stall mfhi/mflo and any new mul/div until the result is written.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request qualifier from Control; high when the current instruction is an R-type with func in {0x11,0x13,0x18,0x19,0x1a,0x1b}.
- Func  input  6  instruction func field.
- RsVal  input  WIDTH  rs operand (multiplicand or dividend; source for mthi/mtlo).
- RtVal  input  WIDTH  rt operand (multiplier or divisor).
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse when HI/LO receive a mul/div result.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Immediately clears HI=0, LO=0, Busy=0, Done=0.
  - FSM goes to IDLE and the counter to 0.
  - Reset mid-operation abandons the operation: no Done, and HI/LO stay 0.
- States:
  - IDLE, CALC, FIX.
  - Busy=1 exactly when state is CALC or FIX.
- IDLE, Start sampled at a rising edge:
  - func 0x18 mult / 0x1a div (signed), 0x19 multu / 0x1b divu (unsigned): latch operand magnitudes and the result-sign flags, clear the counter, go to CALC.
  - func 0x11 mthi: HI<=RsVal at that edge; LO unchanged; stay in IDLE; Done not pulsed.
  - func 0x13 mtlo: LO<=RsVal at that edge, same rules as mthi.
  - Any other func: ignored.
- CALC:
  - One iteration per cycle for exactly WIDTH cycles.
  - Multiply: shift-add on the unsigned magnitudes, producing a 2*WIDTH product.
  - Divide: restoring division on the unsigned magnitudes, producing quotient and remainder.
  - When the counter reaches WIDTH-1, go to FIX.
- FIX (1 cycle):
  - Apply sign correction. Signed product is negated if the operand signs differ. Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
  - At the edge leaving FIX: HI<=product[2W-1:W] or remainder; LO<=product[W-1:0] or quotient; Done<=1; go to IDLE.
- Timing: Start accepted at the edge ending cycle N gives:
  - Busy=1 in cycles N+1..N+33.
  - Busy=0, Done=1 and new HI/LO in cycle N+34.
  - Done=0 in cycle N+35 unless a new result lands.
- Start while Busy=1: ignored entirely, including mthi/mtlo; operands are not re-latched.
- Start in the same cycle Done=1 (state IDLE): accepted normally.
- Divide by zero (RtVal=0):
  - Full latency applies.
  - HI=RsVal (raw dividend), LO=all ones, for both div and divu.
- Signed overflow, div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- HI/LO are read combinationally (register outputs). During Busy they hold their previous values.

Test Plan:
- mult, RsVal=7, RtVal=0xFFFFFFFD, Start at cycle N:
  - Busy high N+1..N+33.
  - Cycle N+34: Done=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu, RsVal=RtVal=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001.
  - Repeat as mult: HI=0, LO=1.
- div tests:
  - div, RsVal=0xFFFFFFF9 (-7), RtVal=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu, RsVal=100, RtVal=7: LO=14, HI=2.
- Edge cases:
  - div by zero, RsVal=0x12345678, RtVal=0: HI=0x12345678, LO=0xFFFFFFFF at N+34.
  - div 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- Busy and reset:
  - Start a new mult at N+5 during Busy: ignored; the original result still arrives at N+34.
  - Pull rst_n low at N+10: Busy, Done, HI, LO go to 0 immediately; no Done afterwards.
- mthi/mtlo:
  - mthi with RsVal=0xDEADBEEF: HI=0xDEADBEEF next cycle, LO unchanged, Done=0, Busy=0.
  - mtlo with RsVal=0x0BADF00D: LO updated.
  - mthi issued while Busy: no change.
